// File: rtl/instruction_issue_queue.sv
// In-order issue FIFO feeding the Tomasulo reservation station: one Adderin pulse per issue, then a settle gap.
// Optional performance counters (issuedCount, stallCycles) are enabled by defining IIQ_PERF_CNT_EN.
module instruction_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inValid,
    input  logic [15:0]   inInstr,
    output logic          inReady,
    input  logic          flush,
    input  logic          disponivel,
    output logic          Adderin,
    output logic [15:0]   instruction,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
`ifdef IIQ_PERF_CNT_EN
    ,
    output logic [15:0]   issuedCount,
    output logic [15:0]   stallCycles
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [3:0]  GAP_LOAD   = 4'(GAP_CYCLES);

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [3:0]    gap_cnt;
    logic          push;
    logic          pop;

    // A full queue refuses pushes even when a pop happens on the same edge.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign inReady = !full;
    assign push    = inValid && inReady;
    assign pop     = (state == IDLE) && !empty && disponivel;

    always_ff @(posedge clk) begin
        if (push && !reset && !flush)
            mem[wr_ptr] <= inInstr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            Adderin     <= 1'b0;
            instruction <= 16'h0000;
            gap_cnt     <= 4'd0;
        end else if (flush) begin
            // Flushed words are dropped and a registered-but-cut pulse counts as not issued.
            rd_ptr  <= wr_ptr;
            count   <= '0;
            state   <= IDLE;
            Adderin <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        instruction <= mem[rd_ptr];
                        Adderin     <= 1'b1;
                        rd_ptr      <= rd_ptr + AW'(1);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    Adderin <= 1'b0;
                    gap_cnt <= GAP_LOAD;
                    state   <= GAP;
                end
                GAP: begin
                    // The station's busy bits settle here, so disponivel is not trusted yet.
                    Adderin <= 1'b0;
                    if (gap_cnt <= 4'd1) begin
                        gap_cnt <= 4'd0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    Adderin <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef IIQ_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            issuedCount <= 16'd0;
            stallCycles <= 16'd0;
        end else begin
            if (pop && !flush)
                issuedCount <= issuedCount + 16'd1;
            if ((state == IDLE) && !empty && !disponivel && (stallCycles != 16'hFFFF))
                stallCycles <= stallCycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_issue_queue.sv
// Self-checking bench for instruction_issue_queue: directed scenarios plus randomized traffic vs a queue model.
// Connects the optional counters when IIQ_PERF_CNT_EN is defined.
module tb_instruction_issue_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int G     = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          inValid = 1'b0;
    logic [15:0]   inInstr = 16'h0;
    logic          flush = 1'b0;
    logic          disponivel = 1'b0;
    logic          inReady;
    logic          Adderin;
    logic [15:0]   instruction;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
`ifdef IIQ_PERF_CNT_EN
    logic [15:0]   issuedCount;
    logic [15:0]   stallCycles;
`endif

    instruction_issue_queue #(.DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inInstr(inInstr), .inReady(inReady),
        .flush(flush), .disponivel(disponivel), .Adderin(Adderin), .instruction(instruction),
        .count(count), .empty(empty), .full(full)
`ifdef IIQ_PERF_CNT_EN
        , .issuedCount(issuedCount), .stallCycles(stallCycles)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a word queue plus the edge number of the last issue.
    logic [15:0] q[$];
    logic        exp_adderin;
    logic [15:0] exp_instr;
    int          cyc;
    int          last_issue;
    int          exp_issued;
    int          exp_stall;
    int          n_cmp;
    int          n_fail;

    task automatic drive(input logic v, input logic [15:0] w, input logic d, input logic f);
        inValid    = v;
        inInstr    = w;
        disponivel = d;
        flush      = f;
    endtask

    // Advance the model by one edge using the current inputs, then step the DUT and settle.
    task automatic tick();
        bit idle, do_push, do_pop;
        if (reset) begin
            q.delete();
            exp_adderin = 1'b0;
            exp_instr   = 16'h0;
            last_issue  = -1000;
            exp_issued  = 0;
            exp_stall   = 0;
        end else begin
            idle = (cyc - last_issue) >= (2 + G);
            if (idle && q.size() > 0 && !disponivel && exp_stall < 65535)
                exp_stall++;
            if (flush) begin
                q.delete();
                exp_adderin = 1'b0;
                last_issue  = -1000;
            end else begin
                do_push     = inValid && (q.size() < DEPTH);
                do_pop      = idle && (q.size() > 0) && disponivel;
                exp_adderin = 1'b0;
                if (do_pop) begin
                    exp_instr   = q.pop_front();
                    exp_adderin = 1'b1;
                    last_issue  = cyc;
                    exp_issued  = (exp_issued + 1) % 65536;
                end
                if (do_push)
                    q.push_back(inInstr);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (Adderin !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_adderin: got %b want 0", Adderin); end
        n_cmp++; if (instruction !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h want 0000", instruction); end
        n_cmp++; if (count !== '0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || inReady !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_flags: got empty=%b full=%b inReady=%b want 1 0 1", empty, full, inReady);
        end
`ifdef IIQ_PERF_CNT_EN
        n_cmp++; if (issuedCount !== 16'h0 || stallCycles !== 16'h0) begin
            n_fail++; $display("[TB] FAIL reset_perf: got %0d/%0d want 0/0", issuedCount, stallCycles);
        end
`endif
    endtask

    task automatic test_basic();
        logic [15:0] w[3];
        int pulse_at[3];
        int np;
        w  = '{16'h1281, 16'h0A04, 16'h2C10};
        np = 0;
        for (int c = 0; c < 18; c++) begin
            drive(c < 3, (c < 3) ? w[c] : 16'h0, 1'b1, 1'b0);
            tick();
            n_cmp++; if (Adderin !== exp_adderin) begin n_fail++; $display("[TB] FAIL basic_adderin c=%0d: got %b want %b", c, Adderin, exp_adderin); end
            if (Adderin === 1'b1 && np < 3) begin
                n_cmp++; if (instruction !== w[np]) begin n_fail++; $display("[TB] FAIL basic_word%0d: got %h want %h", np, instruction, w[np]); end
                pulse_at[np] = c;
                np++;
            end
        end
        n_cmp++; if (np != 3) begin n_fail++; $display("[TB] FAIL basic_pulses: got %0d want 3", np); end
        if (np == 3) begin
            n_cmp++; if (pulse_at[0] != 1) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d want 1", pulse_at[0]); end
            n_cmp++; if (pulse_at[1] - pulse_at[0] != 3 || pulse_at[2] - pulse_at[1] != 3) begin
                n_fail++; $display("[TB] FAIL basic_spacing: got %0d,%0d want 3,3", pulse_at[1] - pulse_at[0], pulse_at[2] - pulse_at[1]);
            end
        end
        n_cmp++; if (count !== '0) begin n_fail++; $display("[TB] FAIL basic_count: got %0d want 0", count); end
    endtask

    task automatic test_fill();
        int np;
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, 16'($urandom), 1'b0, 1'b0);
            tick();
            n_cmp++; if (Adderin !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_nopulse c=%0d: got %b want 0", c, Adderin); end
        end
        n_cmp++; if (full !== 1'b1 || inReady !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_full: got full=%b inReady=%b want 1 0", full, inReady); end
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("[TB] FAIL fill_count: got %0d want 8", count); end
        np = 0;
        for (int c = 0; c < 30; c++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            tick();
            n_cmp++; if (Adderin !== exp_adderin) begin n_fail++; $display("[TB] FAIL fill_adderin c=%0d: got %b want %b", c, Adderin, exp_adderin); end
            if (Adderin === 1'b1) begin
                np++;
                n_cmp++; if (instruction !== exp_instr) begin n_fail++; $display("[TB] FAIL fill_word: got %h want %h", instruction, exp_instr); end
            end
        end
        n_cmp++; if (np != 8) begin n_fail++; $display("[TB] FAIL fill_pulses: got %0d want 8", np); end
        n_cmp++; if (count !== '0) begin n_fail++; $display("[TB] FAIL fill_drain: got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        logic [15:0] w[6];
        int np;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 6; i++) begin
                w[i] = 16'($urandom);
                drive(1'b1, w[i], 1'b0, 1'b0);
                tick();
            end
            np = 0;
            for (int c = 0; c < 22; c++) begin
                drive(1'b0, 16'h0, 1'b1, 1'b0);
                tick();
                if (Adderin === 1'b1) begin
                    if (np < 6) begin
                        n_cmp++; if (instruction !== w[np]) begin n_fail++; $display("[TB] FAIL wrap_word r%0d i%0d: got %h want %h", rep, np, instruction, w[np]); end
                    end
                    np++;
                end
            end
            n_cmp++; if (np != 6) begin n_fail++; $display("[TB] FAIL wrap_pulses r%0d: got %0d want 6", rep, np); end
            n_cmp++; if (count !== '0) begin n_fail++; $display("[TB] FAIL wrap_count r%0d: got %0d want 0", rep, count); end
        end
    endtask

    task automatic test_gap_disp();
        int hold;
        int first_after;
        logic d;
        hold        = int'($urandom_range(3, 8));
        first_after = -1;
        for (int c = 0; c < 30; c++) begin
            d = !(c >= 2 && c < 2 + hold);
            drive(c < 3, 16'h0100 + 16'(c), d, 1'b0);
            tick();
            n_cmp++; if (Adderin !== exp_adderin) begin n_fail++; $display("[TB] FAIL gap_adderin c=%0d: got %b want %b", c, Adderin, exp_adderin); end
            if (!d) begin
                n_cmp++; if (Adderin !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_blocked c=%0d: got %b want 0", c, Adderin); end
            end
            if (Adderin === 1'b1 && c >= 2 && first_after < 0)
                first_after = c;
        end
        n_cmp++; if (first_after != 2 + hold) begin n_fail++; $display("[TB] FAIL gap_resume: got %0d want %0d", first_after, 2 + hold); end
    endtask

    task automatic test_flush();
        int np;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (Adderin !== 1'b1 || instruction !== 16'hA000) begin
            n_fail++; $display("[TB] FAIL flush_issue: got %b/%h want 1/a000", Adderin, instruction);
        end
        drive(1'b1, 16'hBEEF, 1'b1, 1'b1);
        tick();
        n_cmp++; if (Adderin !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_adderin: got %b want 0", Adderin); end
        n_cmp++; if (count !== '0 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (instruction !== 16'hA000) begin n_fail++; $display("[TB] FAIL flush_hold: got %h want a000", instruction); end
        np = 0;
        for (int c = 0; c < 8; c++) begin
            drive(c == 0, 16'h5A5A, 1'b1, 1'b0);
            tick();
            if (Adderin === 1'b1) begin
                np++;
                n_cmp++; if (instruction !== 16'h5A5A) begin n_fail++; $display("[TB] FAIL flush_next: got %h want 5a5a", instruction); end
            end
        end
        n_cmp++; if (np != 1 || count !== '0) begin n_fail++; $display("[TB] FAIL flush_after: got pulses=%0d count=%0d want 1 0", np, count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        tick();
        n_cmp++; if (count !== 4'd5 || Adderin !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_pre: got count=%0d adderin=%b want 5 0", count, Adderin); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (Adderin !== 1'b0 || instruction !== 16'h0 || count !== '0 || empty !== 1'b1 || full !== 1'b0 || inReady !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rmid_outputs: got %b %h %0d %b %b %b want 0 0000 0 1 0 1", Adderin, instruction, count, empty, full, inReady);
        end
`ifdef IIQ_PERF_CNT_EN
        n_cmp++; if (issuedCount !== 16'h0) begin n_fail++; $display("[TB] FAIL rmid_issued: got %0d want 0", issuedCount); end
`endif
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp++; if (Adderin !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_quiet c=%0d: got %b want 0", c, Adderin); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom % 2), 16'($urandom), ($urandom % 4) != 0, ($urandom % 40) == 0);
            tick();
            n_cmp++; if (Adderin !== exp_adderin) begin n_fail++; $display("[TB] FAIL rand_adderin c=%0d: got %b want %b", c, Adderin, exp_adderin); end
            n_cmp++; if (instruction !== exp_instr) begin n_fail++; $display("[TB] FAIL rand_instr c=%0d: got %h want %h", c, instruction, exp_instr); end
            n_cmp++; if (count !== (AW+1)'(q.size())) begin n_fail++; $display("[TB] FAIL rand_count c=%0d: got %0d want %0d", c, count, q.size()); end
            n_cmp++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || inReady !== (q.size() != DEPTH)) begin
                n_fail++; $display("[TB] FAIL rand_flags c=%0d: got full=%b empty=%b inReady=%b size=%0d", c, full, empty, inReady, q.size());
            end
        end
`ifdef IIQ_PERF_CNT_EN
        n_cmp++; if (issuedCount !== 16'(exp_issued)) begin n_fail++; $display("[TB] FAIL rand_issued: got %0d want %0d", issuedCount, exp_issued); end
        n_cmp++; if (stallCycles !== 16'(exp_stall)) begin n_fail++; $display("[TB] FAIL rand_stall: got %0d want %0d", stallCycles, exp_stall); end
`endif
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        cyc        = 0;
        last_issue = -1000;
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_gap_disp();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
